nv_minmax_window_seq: RTL and testbench
=======================================

# nv_minmax_window_seq

Streaming window-reduction sequencer for the SDP/PDP unsigned min/max path. It accepts a stream of beats, each carrying LANES unsigned elements, over a valid/ready handshake, and reduces each beat combinationally. It then keeps a running min or max with its beat and lane position across a programmable number of beats, and returns one result per window on a valid/ready output. Windows run back-to-back, and the configuration is captured per window.

## Interface
- WIDTH, 8, element width in bits (unsigned)
- LANES, 4, elements per beat; lane 0 = in_pd[WIDTH-1:0]
- LANE_IW, 2, lane index width; must satisfy 2^LANE_IW >= LANES
- LEN_W, 8, beat-count width; a window holds cfg_len+1 beats

- nvdla_core_clk  in  1  clock
- nvdla_core_rst  in  1  reset, asynchronous, active-high
- cfg_min_max  in  1  0 = min, 1 = max; sampled on the first accepted beat of a window
- cfg_len  in  LEN_W  beats per window minus 1; sampled with cfg_min_max
- in_pvld  in  1  input beat valid
- in_prdy  out  1  input beat ready
- in_pd  in  LANES*WIDTH  input beat
- out_pvld  out  1  result valid
- out_prdy  in  1  result ready
- out_value  out  WIDTH  winning element
- out_lane  out  LANE_IW  lane of winner
- out_beat  out  LEN_W  beat number of winner within window (0-based)
- busy  out  1  window in progress (state != IDLE)

## Operation
- The FSM has three states: IDLE, ACC and DONE.
- A beat is accepted on a rising edge where in_pvld && in_prdy.
- in_prdy = (state != DONE). It is combinational from state only.
- **Per-beat reduction** (combinational, unsigned):
  - max: scan lanes 0..LANES-1 with start value 0. A lane replaces the candidate when element >= candidate, so the highest lane wins ties.
  - min: scan with start value all-ones. A lane replaces the candidate when element < candidate, so the lowest lane wins ties. If every element is all-ones, the result is lane 0.
- **IDLE:**
  - On an accepted beat: latch cfg_min_max and cfg_len; load the accumulator with the beat result (value, lane); set beat_cnt = 0 and win_beat = 0.
  - If cfg_len == 0, go to DONE. Otherwise go to ACC.
- **ACC:**
  - On an accepted beat: beat_cnt += 1.
  - Compare the beat result against the accumulator. In max mode replace when beat_val >= acc_val (later beat wins ties). In min mode replace when beat_val < acc_val (earlier beat wins ties).
  - On replace, store value, lane and win_beat = new beat_cnt.
  - When the new beat_cnt == latched len, go to DONE.
- **DONE:**
  - out_pvld = 1 and out_value/out_lane/out_beat are driven from the accumulator.
  - On out_prdy, go to IDLE.
- cfg_* changes outside the IDLE accept cycle have no effect on the current window.
- A beat_cnt wrap is impossible, because the FSM leaves ACC at beat_cnt == len <= 2^LEN_W-1.
- Reset at any point drops the partial window. No result is emitted for it.

## Timing
- Reset values:
  - state = IDLE, so in_prdy = 1 and busy = 0.
  - out_pvld = 0.
  - out_value, out_lane and out_beat = 0.
  - Accumulator, beat_cnt and latched cfg = 0.
- Result latency: out_pvld rises the cycle after the last beat of the window is accepted.
- Throughput: a window of N beats occupies at least N+1 cycles. in_prdy is 0 for every cycle spent in DONE.
- While out_pvld=1 && out_prdy=0, all out_* fields stay stable and no input is accepted.
- If out_prdy is high in the first DONE cycle, the handshake completes. in_prdy returns to 1 on the next cycle, and a new beat can be accepted there.
- All outputs are registered, except in_prdy and busy, which are decoded from the state register.

## Test plan
- max, len=0, beat lanes0..3 = {0x05,0x80,0x80,0x10}, out_prdy=1 -> one cycle after accept: value=0x80, lane=2, beat=0; then in_prdy=1.
- min, len=2, beats {3,9,7,4}, {5,2,8,2}, {2,6,6,6} -> value=2, lane=1, beat=1.
- max, len=1, two beats all 0x7F -> value=0x7F, lane=3, beat=1. min, len=1, two beats all 0xFF -> value=0xFF, lane=0, beat=0.
- Backpressure: hold out_prdy=0 for 5 cycles after result with in_pvld=1 -> out_* stable, in_prdy=0, no beat accepted. Raise out_prdy -> a new window's first beat is accepted on the next cycle.
- Change cfg_min_max from 1 to 0 and cfg_len from 3 to 0 after beat 0 of a max/len=3 window -> the window still takes 4 beats and reports the max.
- Assert nvdla_core_rst after 2 of 4 beats, for a partial cycle -> outputs return to reset values immediately. A following len=0 window produces only its own result.

Source files
------------

// File: rtl/nv_minmax_window_seq.sv
// Streaming min/max window reducer: reduces each LANES-wide beat, tracks the running
// winner (value, lane, beat) over cfg_len+1 beats and hands one result out per window.
module nv_minmax_window_seq #(
    parameter int WIDTH   = 8,
    parameter int LANES   = 4,
    parameter int LANE_IW = 2,
    parameter int LEN_W   = 8
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rst,
    input  logic                     cfg_min_max,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     in_pvld,
    output logic                     in_prdy,
    input  logic [LANES*WIDTH-1:0]   in_pd,
    output logic                     out_pvld,
    input  logic                     out_prdy,
    output logic [WIDTH-1:0]         out_value,
    output logic [LANE_IW-1:0]       out_lane,
    output logic [LEN_W-1:0]         out_beat,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;

    logic                 mode_q, mode_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [WIDTH-1:0]     acc_val_q, acc_val_d;
    logic [LANE_IW-1:0]   acc_lane_q, acc_lane_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [LEN_W-1:0]     win_q, win_d;

    logic                 out_pvld_q;
    logic [WIDTH-1:0]     out_value_q;
    logic [LANE_IW-1:0]   out_lane_q;
    logic [LEN_W-1:0]     out_beat_q;

    logic                 accept;
    logic                 red_mode;
    logic [WIDTH-1:0]     red_val;
    logic [LANE_IW-1:0]   red_lane;
    logic [WIDTH-1:0]     elem;
    logic [LEN_W-1:0]     cnt_inc;
    logic                 replace;
    logic                 load_out;

    assign accept  = in_pvld && in_prdy;
    assign cnt_inc = cnt_q + LEN_W'(1);

    // The first beat of a window must be reduced with the live cfg, later beats with the latched one.
    always_comb begin
        red_mode = (state_q == S_IDLE) ? cfg_min_max : mode_q;
        red_val  = red_mode ? '0 : '1;
        red_lane = '0;
        elem     = '0;
        for (int i = 0; i < LANES; i++) begin
            elem = in_pd[i*WIDTH +: WIDTH];
            if (red_mode ? (elem >= red_val) : (elem < red_val)) begin
                red_val  = elem;
                red_lane = LANE_IW'(i);
            end
        end
    end

    assign replace = mode_q ? (red_val >= acc_val_q) : (red_val < acc_val_q);

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (cfg_len == '0) ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (accept && (cnt_inc == len_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_prdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_prdy = (state_q != S_DONE);
        busy    = (state_q != S_IDLE);
    end

    always_comb begin
        mode_d     = mode_q;
        len_d      = len_q;
        acc_val_d  = acc_val_q;
        acc_lane_d = acc_lane_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        if (accept) begin
            if (state_q == S_IDLE) begin
                mode_d     = cfg_min_max;
                len_d      = cfg_len;
                acc_val_d  = red_val;
                acc_lane_d = red_lane;
                cnt_d      = '0;
                win_d      = '0;
            end else if (state_q == S_ACC) begin
                cnt_d = cnt_inc;
                if (replace) begin
                    acc_val_d  = red_val;
                    acc_lane_d = red_lane;
                    win_d      = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            mode_q     <= 1'b0;
            len_q      <= '0;
            acc_val_q  <= '0;
            acc_lane_q <= '0;
            cnt_q      <= '0;
            win_q      <= '0;
        end else begin
            mode_q     <= mode_d;
            len_q      <= len_d;
            acc_val_q  <= acc_val_d;
            acc_lane_q <= acc_lane_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
        end
    end

    // Result registers capture the final accumulator on DONE entry and hold through backpressure.
    assign load_out = (state_d == S_DONE) && (state_q != S_DONE);

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            out_pvld_q  <= 1'b0;
            out_value_q <= '0;
            out_lane_q  <= '0;
            out_beat_q  <= '0;
        end else begin
            out_pvld_q <= (state_d == S_DONE);
            if (load_out) begin
                out_value_q <= acc_val_d;
                out_lane_q  <= acc_lane_d;
                out_beat_q  <= win_d;
            end
        end
    end

    assign out_pvld  = out_pvld_q;
    assign out_value = out_value_q;
    assign out_lane  = out_lane_q;
    assign out_beat  = out_beat_q;

endmodule

// File: tb/tb_nv_minmax_window_seq.sv
// Randomized and directed bench for nv_minmax_window_seq against a flat scan reference model.
module tb_nv_minmax_window_seq;

    localparam int WIDTH   = 8;
    localparam int LANES   = 4;
    localparam int LANE_IW = 2;
    localparam int LEN_W   = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cfg_min_max = 1'b0;
    logic [LEN_W-1:0]       cfg_len = '0;
    logic                   in_pvld = 1'b0;
    logic                   in_prdy;
    logic [LANES*WIDTH-1:0] in_pd = '0;
    logic                   out_pvld;
    logic                   out_prdy = 1'b1;
    logic [WIDTH-1:0]       out_value;
    logic [LANE_IW-1:0]     out_lane;
    logic [LEN_W-1:0]       out_beat;
    logic                   busy;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] bq[$];

    nv_minmax_window_seq #(
        .WIDTH(WIDTH), .LANES(LANES), .LANE_IW(LANE_IW), .LEN_W(LEN_W)
    ) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .cfg_min_max(cfg_min_max),
        .cfg_len(cfg_len),
        .in_pvld(in_pvld),
        .in_prdy(in_prdy),
        .in_pd(in_pd),
        .out_pvld(out_pvld),
        .out_prdy(out_prdy),
        .out_value(out_value),
        .out_lane(out_lane),
        .out_beat(out_beat),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flat scan over (beat, lane) order: max keeps the last occurrence, min the first.
    task automatic ref_model(input logic mode, output int v, output int l, output int b);
        int e;
        v = 0; l = 0; b = 0;
        for (int bi = 0; bi < bq.size(); bi++) begin
            for (int li = 0; li < LANES; li++) begin
                e = int'(bq[bi][li*WIDTH +: WIDTH]);
                if ((bi == 0 && li == 0) || (mode ? (e >= v) : (e < v))) begin
                    v = e; l = li; b = bi;
                end
            end
        end
    endtask

    function automatic logic [7:0] pick_elem();
        case ($urandom_range(0, 3))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'($urandom_range(0, 3));
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic drive_beat(input logic [31:0] pd);
        int t;
        t = 0;
        @(negedge clk);
        in_pvld = 1'b1;
        in_pd   = pd;
        while (!in_prdy && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("beat_ready", 32'(in_prdy), 32'd1);
        @(posedge clk);
        #1;
        in_pvld = 1'b0;
        in_pd   = $urandom;
    endtask

    task automatic run_window(input logic mode, input int len, input int stall, input logic [7:0] new_len,
                              output int ov, output int ol, output int ob);
        int ev, el, eb;
        cfg_min_max = mode;
        cfg_len     = LEN_W'(len);
        if (stall > 0) out_prdy = 1'b0;
        for (int b = 0; b <= len; b++) begin
            drive_beat(bq[b]);
            if (b == 0) begin
                cfg_min_max = ~mode;
                cfg_len     = new_len;
            end
            if (b < len) begin
                @(negedge clk);
                chk("no_early_result", 32'(out_pvld), 32'd0);
                chk("busy_mid", 32'(busy), 32'd1);
            end
        end
        ref_model(mode, ev, el, eb);
        @(negedge clk);
        chk("result_pvld", 32'(out_pvld), 32'd1);
        chk("result_value", 32'(out_value), 32'(ev));
        chk("result_lane", 32'(out_lane), 32'(el));
        chk("result_beat", 32'(out_beat), 32'(eb));
        chk("done_in_prdy", 32'(in_prdy), 32'd0);
        ov = int'(out_value); ol = int'(out_lane); ob = int'(out_beat);
        if (stall > 0) begin
            in_pvld = 1'b1;
            in_pd   = $urandom;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_pvld", 32'(out_pvld), 32'd1);
                chk("stall_value", 32'(out_value), 32'(ev));
                chk("stall_lane", 32'(out_lane), 32'(el));
                chk("stall_beat", 32'(out_beat), 32'(eb));
                chk("stall_in_prdy", 32'(in_prdy), 32'd0);
            end
            out_prdy = 1'b1;
            @(posedge clk);
            #1;
            in_pvld = 1'b0;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        chk("pvld_drop", 32'(out_pvld), 32'd0);
        chk("prdy_back", 32'(in_prdy), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, l, b, len, stall;
        logic mode;
        logic [31:0] w;

        #1;
        chk("rst_in_prdy", 32'(in_prdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pvld", 32'(out_pvld), 32'd0);
        chk("rst_value", 32'(out_value), 32'd0);
        chk("rst_lane", 32'(out_lane), 32'd0);
        chk("rst_beat", 32'(out_beat), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        bq = '{32'h10808005};
        run_window(1'b1, 0, 0, 8'd0, v, l, b);
        chk("d1_value", 32'(v), 32'h80);
        chk("d1_lane", 32'(l), 32'd2);
        chk("d1_beat", 32'(b), 32'd0);

        bq = '{32'h04070903, 32'h02080205, 32'h06060602};
        run_window(1'b0, 2, 0, 8'd0, v, l, b);
        chk("d2_value", 32'(v), 32'd2);
        chk("d2_lane", 32'(l), 32'd1);
        chk("d2_beat", 32'(b), 32'd1);

        // Mid-window asynchronous reset, asserted and released between clock edges.
        cfg_min_max = 1'b1;
        cfg_len     = 8'd3;
        drive_beat(32'h11223344);
        drive_beat(32'h55667788);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_prdy", 32'(in_prdy), 32'd1);
        chk("arst_pvld", 32'(out_pvld), 32'd0);
        chk("arst_value", 32'(out_value), 32'd0);
        chk("arst_lane", 32'(out_lane), 32'd0);
        chk("arst_beat", 32'(out_beat), 32'd0);
        #1 rst = 1'b0;
        bq = '{32'h01020304};
        run_window(1'b1, 0, 0, 8'd0, v, l, b);
        chk("post_rst_value", 32'(v), 32'h04);
        chk("post_rst_lane", 32'(l), 32'd0);

        bq = '{32'h7F7F7F7F, 32'h7F7F7F7F};
        run_window(1'b1, 1, 0, 8'd0, v, l, b);
        chk("d3_value", 32'(v), 32'h7F);
        chk("d3_lane", 32'(l), 32'd3);
        chk("d3_beat", 32'(b), 32'd1);

        bq = '{32'hFFFFFFFF, 32'hFFFFFFFF};
        run_window(1'b0, 1, 5, 8'd0, v, l, b);
        chk("d4_value", 32'(v), 32'hFF);
        chk("d4_lane", 32'(l), 32'd0);
        chk("d4_beat", 32'(b), 32'd0);

        bq = '{32'h01020304, 32'h0A0B0C0D, 32'h90000000, 32'h00000005};
        run_window(1'b1, 3, 0, 8'd0, v, l, b);
        chk("d5_value", 32'(v), 32'h90);
        chk("d5_lane", 32'(l), 32'd3);
        chk("d5_beat", 32'(b), 32'd2);

        for (int k = 0; k < 60; k++) begin
            mode  = 1'($urandom);
            len   = $urandom_range(0, 6);
            stall = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 4) : 0;
            bq.delete();
            for (int j = 0; j <= len; j++) begin
                w = {pick_elem(), pick_elem(), pick_elem(), pick_elem()};
                bq.push_back(w);
            end
            run_window(mode, len, stall, 8'($urandom), v, l, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
